wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Producer side of the register-file write port: merges single-cycle ALU results and long-latency results (LSU/multi-cycle units) into the one write port per cycle (rd_addr/rd_data/rd_wren).
- Buffers long-latency results in a small FIFO.
- Keeps a pending-destination scoreboard for the hazard unit.
- Sits between the EX/MEM back-end and the regfile, with a registered output stage.

Parameters:
- DEPTH, 4, long-latency result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8, consecutive ALU wins with the FIFO non-empty before the FIFO is forced to win.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_alu_valid  in  1  ALU result valid this cycle; no backpressure.
- i_alu_rd_addr  in  5  ALU destination register.
- i_alu_rd_data  in  32  ALU result.
- i_lsu_valid  in  1  long-latency result offered.
- o_lsu_ready  out  1  FIFO can accept; transfer when valid & ready.
- i_lsu_rd_addr  in  5  long-latency destination.
- i_lsu_rd_data  in  32  long-latency result.
- i_issue_valid  in  1  long-latency op dispatched this cycle.
- i_issue_rd_addr  in  5  its destination (scoreboard set).
- o_pending  out  32  bit r = 1 means a long-latency write to xr is outstanding.
- o_alu_stall  out  1  pipeline must not present an ALU result this cycle.
- o_drop_err  out  1  sticky: an ALU result was presented during o_alu_stall.
- o_rd_addr  out  5  to regfile i_rd_addr.
- o_rd_data  out  32  to regfile i_rd_data.
- o_rd_wren  out  1  to regfile i_rd_wren.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_pending=0, o_alu_stall=0, o_drop_err=0.
  - State: FIFO empty, starve counter 0.
  - o_lsu_ready = !full, so it is 1 after reset.
- Reset asserted mid-operation: FIFO contents and pending bits are discarded; o_rd_wren drops immediately (asynchronously).
- Output latency: one cycle. The winner selected in cycle N appears on o_rd_* in cycle N+1 with o_rd_wren=1. With no winner, o_rd_wren=0 and o_rd_addr/o_rd_data hold their previous values.
- Arbitration, one write per cycle:
  - o_alu_stall=0: i_alu_valid with rd≠0 wins; otherwise the FIFO head pops if non-empty.
  - o_alu_stall=1: the FIFO head wins. An ALU valid in that cycle is dropped and sets o_drop_err.
  - An ALU result with rd=0 is discarded, does not consume the slot, and the FIFO may pop in the same cycle.
- FIFO:
  - Enqueue when i_lsu_valid & o_lsu_ready.
  - A long-latency result with rd=0 is accepted (handshake completes) but not stored.
  - Enqueue and pop in the same cycle are legal, including when full: ready is !full before the pop, so a full FIFO does not accept that cycle.
  - Pointers wrap modulo DEPTH; an extra wrap bit distinguishes full from empty.
  - Ordering is strictly FIFO.
- Starvation:
  - The counter increments when the ALU wins while the FIFO is non-empty.
  - It resets to 0 on any FIFO pop, or whenever the FIFO is empty.
  - o_alu_stall is registered: it is 1 in the cycle after the counter reaches STARVE_LIMIT, for exactly one cycle.
  - o_alu_stall is also 1 whenever the FIFO is full and i_lsu_valid is high, registered, re-evaluated each cycle.
- Scoreboard:
  - Set: i_issue_valid with rd≠0 sets o_pending[rd] on the next edge.
  - Clear: o_pending[rd] is cleared on the edge on which a FIFO entry for rd is driven onto o_rd_* (o_rd_wren rises).
  - Simultaneous set and clear of the same rd: set wins.
  - o_pending[0] is always 0.
  - An ALU write to a register with its pending bit set is still performed; WAW avoidance is the hazard unit's job.

Decomposition:
- Shared package (e.g. core_pkg): REG_ADDR_W=5, XLEN=32, typedef wb_req_t {logic [4:0] rd; logic [31:0] data}.
- One sub-module: wb_fifo, a parameterised synchronous FIFO of wb_req_t with full/empty, push/pop and an async active-low reset. The arbiter, starvation counter, scoreboard and output register stay in wb_arbiter.

Test Plan:
- ALU only: alu_valid, rd=5, data=0x1234 at cycle N → o_rd_wren=1, addr=5, data=0x1234 at N+1; rd=0 → o_rd_wren stays 0.
- Collision: ALU rd=3 / 0xAA and LSU rd=7 / 0xBB in the same cycle → x3 written at N+1; x7 written at N+2 when the ALU is idle; o_lsu_ready stays 1.
- Full FIFO: push 4 LSU results with ALU valid every cycle → o_lsu_ready=0 after the 4th; o_alu_stall asserts; FIFO entries drain in push order; o_drop_err set if the ALU stays valid during the stall.
- Starvation, DEPTH=4, STARVE_LIMIT=8: one FIFO entry plus continuous ALU traffic → o_alu_stall pulses after 8 ALU wins; the FIFO entry is written the next cycle.
- Scoreboard: issue rd=9 → o_pending[9]=1 next cycle; LSU result rd=9 written → bit clears on the write edge; issue rd=9 on that same edge → bit stays 1; issue rd=0 → o_pending unchanged.
- Reset mid-stream: drop i_reset_n with 3 FIFO entries and pending bits set → o_rd_wren=0 and o_pending=0 immediately; after release the FIFO is empty, o_lsu_ready=1, and there are no stale writes.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
package wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus: ALU/long-latency producers, issue tap, scoreboard and regfile port.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic                  i_alu_valid;
  logic [REG_ADDR_W-1:0] i_alu_rd_addr;
  logic [XLEN-1:0]       i_alu_rd_data;
  logic                  i_lsu_valid;
  logic                  o_lsu_ready;
  logic [REG_ADDR_W-1:0] i_lsu_rd_addr;
  logic [XLEN-1:0]       i_lsu_rd_data;
  logic                  i_issue_valid;
  logic [REG_ADDR_W-1:0] i_issue_rd_addr;
  logic [XLEN-1:0]       o_pending;
  logic                  o_alu_stall;
  logic                  o_drop_err;
  logic [REG_ADDR_W-1:0] o_rd_addr;
  logic [XLEN-1:0]       o_rd_data;
  logic                  o_rd_wren;

  // arbiter side
  modport slave (
    input  i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    input  i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    input  i_issue_valid, i_issue_rd_addr,
    output o_lsu_ready, o_pending, o_alu_stall, o_drop_err,
    output o_rd_addr, o_rd_data, o_rd_wren
  );

  // back-end / regfile side
  modport master (
    output i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    output i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    output i_issue_valid, i_issue_rd_addr,
    input  o_lsu_ready, o_pending, o_alu_stall, o_drop_err,
    input  o_rd_addr, o_rd_data, o_rd_wren
  );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests; wrap bit separates full from empty.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  input  logic    i_push,
  input  wb_req_t i_din,
  input  logic    i_pop,
  output wb_req_t o_dout,
  output logic    o_full,
  output logic    o_empty
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // push is judged against full before the pop, so a full FIFO never accepts
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_dout  = mem[rd_ptr[AW-1:0]];

  // pointer update; reset discards contents by collapsing the pointers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage write; data needs no reset since empty pointers hide it
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and long-latency results onto the single regfile write port,
// with starvation guard, pending-destination scoreboard and registered output.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  wb_arbiter_if.slave  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  wb_req_t         head, push_req, alu_req, win_req, out_q;
  logic            full, empty, push, pop, alu_ok, alu_win, win;
  logic            wren_q, stall_q, stall_d, drop_q;
  logic [CW-1:0]   starve_cnt, starve_nxt;
  logic [XLEN-1:0] pend_q, pend_nxt;

  assign push_req = '{rd: bus.i_lsu_rd_addr, data: bus.i_lsu_rd_data};
  assign alu_req  = '{rd: bus.i_alu_rd_addr, data: bus.i_alu_rd_data};
  // rd=0 results complete the handshake but are never stored
  assign push     = bus.i_lsu_valid && !full && (bus.i_lsu_rd_addr != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (push),
    .i_din     (push_req),
    .i_pop     (pop),
    .o_dout    (head),
    .o_full    (full),
    .o_empty   (empty)
  );

  // one winner per cycle: ALU unless stalled or writing x0, else FIFO head
  always_comb begin
    alu_ok  = bus.i_alu_valid && (bus.i_alu_rd_addr != '0);
    alu_win = alu_ok && !stall_q;
    pop     = !alu_win && !empty;
    win     = alu_win || pop;
    win_req = alu_win ? alu_req : head;
  end

  // starvation count of ALU wins over a waiting FIFO; stall pulses when it hits the limit
  always_comb begin
    starve_nxt = starve_cnt;
    if (empty || pop)  starve_nxt = '0;
    else if (alu_win)  starve_nxt = starve_cnt + 1'b1;
    stall_d = (starve_nxt == CW'(STARVE_LIMIT)) || (full && bus.i_lsu_valid);
  end

  // scoreboard: clear on FIFO write-back, set on issue; set wins, x0 never pending
  always_comb begin
    pend_nxt = pend_q;
    if (pop) pend_nxt[head.rd] = 1'b0;
    if (bus.i_issue_valid && (bus.i_issue_rd_addr != '0)) pend_nxt[bus.i_issue_rd_addr] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // registered write port; address/data hold when idle
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wren_q <= 1'b0;
      out_q  <= '0;
    end else begin
      wren_q <= win;
      if (win) out_q <= win_req;
    end
  end

  // starvation counter and stall register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      stall_q    <= stall_d;
    end
  end

  // pending bits and sticky drop error
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_q <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      if (stall_q && bus.i_alu_valid) drop_q <= 1'b1;
    end
  end

  assign bus.o_lsu_ready = !full;
  assign bus.o_pending   = pend_q;
  assign bus.o_alu_stall = stall_q;
  assign bus.o_drop_err  = drop_q;
  assign bus.o_rd_wren   = wren_q;
  assign bus.o_rd_addr   = out_q.rd;
  assign bus.o_rd_data   = out_q.data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_wb_arbiter;
  logic i_clk = 1'b0;
  logic i_reset_n;
  int   n_pass = 0;
  int   n_tot  = 0;

  wb_arbiter_if bus();

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird;
    logic        ew;  logic [4:0] ea;  logic [31:0] ed;
    logic        er;  logic       es;  logic        edr;
    logic [31:0] ep;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic iv, logic [4:0] ird,
                              logic ew, logic [4:0] ea, logic [31:0] ed,
                              logic er, logic es, logic edr, logic [31:0] ep);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.ew = ew; v.ea = ea; v.ed = ed;
    v.er = er; v.es = es; v.edr = edr; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ird);
    bus.i_alu_valid = av; bus.i_alu_rd_addr = ard; bus.i_alu_rd_data = ad;
    bus.i_lsu_valid = lv; bus.i_lsu_rd_addr = lrd; bus.i_lsu_rd_data = ld;
    bus.i_issue_valid = iv; bus.i_issue_rd_addr = ird;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".wren"}, 32'(bus.o_rd_wren), 32'(w));
    if (w) begin
      chk({tag, ".addr"}, 32'(bus.o_rd_addr), 32'(a));
      chk({tag, ".data"}, bus.o_rd_data, d);
    end
  endtask

  localparam logic [31:0] P9 = 32'h0000_0200;

  initial begin
    i_reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // idle-path / ALU-only / collision
    tbl.push_back(mk(1, 5, 32'h1234, 0, 0, 0, 0, 0,  1, 5, 32'h1234, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'h5555, 0, 0, 0, 0, 0,  0, 5, 32'h1234, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,  0, 5, 32'h1234, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 32'hAA,   1, 7, 32'hBB, 0, 0,  1, 3, 32'hAA, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,  1, 7, 32'hBB, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,  0, 7, 32'hBB, 1, 0, 0, 0));
    // scoreboard set / clear / set-wins / rd=0 issue
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 1, 9,  0, 7, 32'hBB, 1, 0, 0, P9));
    tbl.push_back(mk(0, 0, 0,        1, 9, 32'h99, 0, 0,  0, 7, 32'hBB, 1, 0, 0, P9));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,  1, 9, 32'h99, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 1, 9,  0, 9, 32'h99, 1, 0, 0, P9));
    tbl.push_back(mk(0, 0, 0,        1, 9, 32'h77, 0, 0,  0, 9, 32'h99, 1, 0, 0, P9));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 1, 9,  1, 9, 32'h77, 1, 0, 0, P9));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 1, 0,  0, 9, 32'h77, 1, 0, 0, P9));
    tbl.push_back(mk(0, 0, 0,        1, 9, 32'h11, 0, 0,  0, 9, 32'h77, 1, 0, 0, P9));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,  1, 9, 32'h11, 1, 0, 0, 0));
    // LSU rd=0 not stored; ALU rd=0 lets FIFO pop same cycle
    tbl.push_back(mk(0, 0, 0,        1, 0, 32'hDEAD, 0, 0,  0, 9, 32'h11, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,  0, 9, 32'h11, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,        1, 4, 32'h44, 0, 0,  0, 9, 32'h11, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'hEE,   0, 0, 0, 0, 0,  1, 4, 32'h44, 1, 0, 0, 0));
    // fill FIFO under ALU pressure, full-stall, drop error, in-order drain
    tbl.push_back(mk(1, 1, 32'h101,  1, 10, 32'hA0, 0, 0,  1, 1,  32'h101, 1, 0, 0, 0));
    tbl.push_back(mk(1, 2, 32'h102,  1, 11, 32'hA1, 0, 0,  1, 2,  32'h102, 1, 0, 0, 0));
    tbl.push_back(mk(1, 3, 32'h103,  1, 12, 32'hA2, 0, 0,  1, 3,  32'h103, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4, 32'h104,  1, 13, 32'hA3, 0, 0,  1, 4,  32'h104, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 32'h105,  1, 14, 32'hA4, 0, 0,  1, 5,  32'h105, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6, 32'h106,  1, 14, 32'hA4, 0, 0,  1, 10, 32'hA0,  1, 1, 1, 0));
    tbl.push_back(mk(1, 7, 32'h107,  1, 14, 32'hA4, 0, 0,  1, 11, 32'hA1,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,        1, 12, 32'hA2,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,        1, 13, 32'hA3,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,        1, 14, 32'hA4,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 0,        0, 14, 32'hA4,  1, 0, 1, 0));

    // reset state
    step(); step();
    chk("rst.wren",  32'(bus.o_rd_wren), 0);
    chk("rst.addr",  32'(bus.o_rd_addr), 0);
    chk("rst.data",  bus.o_rd_data, 0);
    chk("rst.pend",  bus.o_pending, 0);
    chk("rst.stall", 32'(bus.o_alu_stall), 0);
    chk("rst.drop",  32'(bus.o_drop_err), 0);
    chk("rst.ready", 32'(bus.o_lsu_ready), 1);
    #3 i_reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld, tbl[i].iv, tbl[i].ird);
      step();
      chk_out(t, tbl[i].ew, tbl[i].ea, tbl[i].ed);
      chk({t, ".ready"}, 32'(bus.o_lsu_ready), 32'(tbl[i].er));
      chk({t, ".stall"}, 32'(bus.o_alu_stall), 32'(tbl[i].es));
      chk({t, ".drop"},  32'(bus.o_drop_err),  32'(tbl[i].edr));
      chk({t, ".pend"},  bus.o_pending, tbl[i].ep);
    end

    // reset mid-stream: three queued entries, three pending bits
    drive(1, 1, 32'h1, 1, 21, 32'h210, 1, 21); step();
    drive(1, 2, 32'h2, 1, 22, 32'h220, 1, 22); step();
    drive(1, 3, 32'h3, 1, 23, 32'h230, 1, 23); step();
    chk("mid.pend_pre", bus.o_pending, 32'h00E0_0000);
    chk("mid.wren_pre", 32'(bus.o_rd_wren), 1);
    drive(1, 4, 32'h4, 0, 0, 0, 0, 0);
    #2 i_reset_n = 1'b0;
    #1;
    chk("mid.wren",  32'(bus.o_rd_wren), 0);
    chk("mid.pend",  bus.o_pending, 0);
    chk("mid.ready", 32'(bus.o_lsu_ready), 1);
    chk("mid.drop",  32'(bus.o_drop_err), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    #3 i_reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post%0d.wren", i), 32'(bus.o_rd_wren), 0);
      chk($sformatf("post%0d.ready", i), 32'(bus.o_lsu_ready), 1);
    end

    // starvation: one queued entry, eight ALU wins, one-cycle stall, entry written
    drive(1, 1, 32'h11, 1, 20, 32'hC0, 0, 0); step();
    chk_out("st0", 1, 1, 32'h11);
    for (int k = 1; k <= 8; k++) begin
      drive(1, 5'(k + 1), 32'(k), 0, 0, 0, 0, 0);
      step();
      chk_out($sformatf("st%0d", k), 1, 5'(k + 1), 32'(k));
      chk($sformatf("st%0d.stall", k), 32'(bus.o_alu_stall), (k == 8) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk_out("st9", 1, 20, 32'hC0);
    chk("st9.stall", 32'(bus.o_alu_stall), 0);
    step();
    chk("st10.wren", 32'(bus.o_rd_wren), 0);
    chk("st10.drop", 32'(bus.o_drop_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
